// File: rtl/da_line_writer.sv
// Ping-pong line-buffer writer: streams pixels into buffer 0/1 alternately and flags each full line.
// Optional sticky Overrun flag for sources that cannot tolerate back-pressure: define DA_WR_OVERRUN_EN.
module da_line_writer #(
  parameter int DATA_W  = 24,
  parameter int LINE_PX = 640,
  parameter int ADDR_W  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              CSDisplay,
  input  logic [DATA_W-1:0] PixIn,
  input  logic              PixValid,
  output logic              PixReady,
  input  logic              Buf0Empty,
  input  logic              Buf1Empty,
  output logic              WE0,
  output logic              WE1,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [DATA_W-1:0] WrData,
  output logic              Buf0Full,
  output logic              Buf1Full,
`ifdef DA_WR_OVERRUN_EN
  output logic              LineDone,
  output logic              Overrun
`else
  output logic              LineDone
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_PX - 1);

  state_t              r_state;
  logic                r_sel;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_we;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_line_done;
  logic [1:0]          r_full;
  logic [1:0]          r_empty_prev;

  logic [1:0]          w_empty;
  logic [1:0]          w_empty_rise;
  logic                w_accept;
  logic                w_line_end;
  logic                w_sel_empty;
  logic                w_sel_full;

  assign w_empty      = {Buf1Empty, Buf0Empty};
  assign w_empty_rise = w_empty & ~r_empty_prev;
  assign PixReady     = (r_state == ST_FILL) && CSDisplay;
  assign w_accept     = PixValid && PixReady;
  assign w_line_end   = w_accept && (r_addr == LAST_ADDR);
  assign w_sel_empty  = w_empty[r_sel];
  assign w_sel_full   = r_full[r_sel];

  // Full flags: a completed line sets the flag; only an Empty rising edge clears it,
  // so a controller that simply holds Empty high cannot release a freshly written buffer.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      localparam logic BUF_ID = 1'(gi);

      always_ff @(posedge clock) begin
        if (reset) begin
          r_empty_prev[gi] <= 1'b0;
          r_full[gi]       <= 1'b0;
        end else begin
          r_empty_prev[gi] <= w_empty[gi];
          if (w_line_end && (r_sel == BUF_ID)) begin
            r_full[gi] <= 1'b1;
          end else if (w_empty_rise[gi]) begin
            r_full[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sel       <= 1'b0;
      r_addr      <= '0;
      r_we        <= 2'b00;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_line_done <= 1'b0;
    end else begin
      r_we        <= 2'b00;
      r_line_done <= 1'b0;
      if (w_accept) begin
        r_we      <= r_sel ? 2'b10 : 2'b01;
        r_wr_addr <= r_addr;
        r_wr_data <= PixIn;
      end

      case (r_state)
        ST_IDLE: begin
          if (CSDisplay) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Full is registered, so an Empty edge seen here only frees the buffer next cycle.
          if (w_sel_empty && !w_sel_full) begin
            r_state <= ST_FILL;
            r_addr  <= '0;
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            if (r_addr == LAST_ADDR) begin
              r_line_done <= 1'b1;
              r_sel       <= ~r_sel;
              r_addr      <= '0;
              r_state     <= ST_WAIT;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign WE0      = r_we[0];
  assign WE1      = r_we[1];
  assign WrAddr   = r_wr_addr;
  assign WrData   = r_wr_data;
  assign Buf0Full = r_full[0];
  assign Buf1Full = r_full[1];
  assign LineDone = r_line_done;

`ifdef DA_WR_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if ((r_state == ST_WAIT) && PixValid && CSDisplay) begin
      r_overrun <= 1'b1;
    end
  end

  assign Overrun = r_overrun;
`endif

endmodule

// File: tb/tb_da_line_writer.sv
// Directed bench for da_line_writer with a 4-pixel line: vector table plus hand-written corner sequences.
module tb_da_line_writer;

  localparam int DATA_W  = 24;
  localparam int LINE_PX = 4;
  localparam int ADDR_W  = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cs    = 1'b0;
  logic              pv    = 1'b0;
  logic [DATA_W-1:0] pix   = '0;
  logic              e0    = 1'b1;
  logic              e1    = 1'b1;
  logic              ready;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              f0;
  logic              f1;
  logic              ld;
`ifdef DA_WR_OVERRUN_EN
  logic              overrun;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  da_line_writer #(
    .DATA_W (DATA_W),
    .LINE_PX(LINE_PX),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .CSDisplay(cs),
    .PixIn    (pix),
    .PixValid (pv),
    .PixReady (ready),
    .Buf0Empty(e0),
    .Buf1Empty(e1),
    .WE0      (we0),
    .WE1      (we1),
    .WrAddr   (wa),
    .WrData   (wd),
    .Buf0Full (f0),
    .Buf1Full (f1),
`ifdef DA_WR_OVERRUN_EN
    .LineDone (ld),
    .Overrun  (overrun)
`else
    .LineDone (ld)
`endif
  );

  typedef struct {
    logic        rst, c, v;
    logic [23:0] px;
    logic        z0, z1;
    logic        rdy, w0, w1;
    logic [1:0]  addr;
    logic [23:0] data;
    logic        fu0, fu1, done;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst, input logic c, input logic v, input int px,
                              input logic z0, input logic z1, input logic rdy,
                              input logic w0, input logic w1, input int addr, input int data,
                              input logic fu0, input logic fu1, input logic done);
    vec_t t;
    t.rst = rst; t.c = c; t.v = v; t.px = 24'(px); t.z0 = z0; t.z1 = z1;
    t.rdy = rdy; t.w0 = w0; t.w1 = w1; t.addr = 2'(addr); t.data = 24'(data);
    t.fu0 = fu0; t.fu1 = fu1; t.done = done;
    vq.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic c, input logic v, input int px,
                       input logic z0, input logic z1);
    reset = rst; cs = c; pv = v; pix = 24'(px); e0 = z0; e1 = z1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Four consecutive accepted pixels base..base+3, then PixValid drops.
  task automatic fill_line(input int base);
    for (int i = 0; i < LINE_PX; i++) begin
      pv  = 1'b1;
      pix = 24'(base + i);
      tick();
    end
    pv = 1'b0;
  endtask

  initial begin
    // Reset state
    drive(1, 0, 0, 0, 1, 1);
    tick();
    tick();
    chk("rst.ready", {31'b0, ready}, 0);
    chk("rst.we0", {31'b0, we0}, 0);
    chk("rst.we1", {31'b0, we1}, 0);
    chk("rst.addr", {30'b0, wa}, 0);
    chk("rst.data", {8'b0, wd}, 0);
    chk("rst.full", {30'b0, f1, f0}, 0);
    chk("rst.done", {31'b0, ld}, 0);

    // rst cs pv pix e0 e1 | rdy we0 we1 addr data f0 f1 ld
    add(1, 1, 1, 'h99, 1, 1, 0, 0, 0, 0, 'h00, 0, 0, 0);
    add(0, 1, 1, 'h99, 1, 1, 0, 0, 0, 0, 'h00, 0, 0, 0);
    add(0, 1, 1, 'h11, 1, 1, 0, 0, 0, 0, 'h00, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      add(0, 1, 1, 'h11 * (k + 1), 1, 1, 1, 1, 0, k, 'h11 * (k + 1), k == 3, 0, k == 3);
    add(0, 1, 1, 'h55, 1, 1, 0, 0, 0, 3, 'h44, 1, 0, 0);
    for (int k = 0; k < 4; k++)
      add(0, 1, 1, 'h55 + 'h11 * k, 1, 1, 1, 0, 1, k, 'h55 + 'h11 * k, 1, k == 3, k == 3);
    // Both full, Empty held high: stall
    for (int k = 0; k < 20; k++)
      add(0, 1, 1, 'h99, 1, 1, 0, 0, 0, 3, 'h88, 1, 1, 0);
    add(0, 1, 1, 'h99, 0, 1, 0, 0, 0, 3, 'h88, 1, 1, 0);
    add(0, 1, 1, 'hA1, 1, 1, 0, 0, 0, 3, 'h88, 0, 1, 0);
    add(0, 1, 1, 'hA1, 1, 1, 0, 0, 0, 3, 'h88, 0, 1, 0);
    add(0, 1, 1, 'hA1, 1, 1, 1, 1, 0, 0, 'hA1, 0, 1, 0);
    add(0, 1, 1, 'hA2, 1, 1, 1, 1, 0, 1, 'hA2, 0, 1, 0);
    // CSDisplay pause at addr 2
    for (int k = 0; k < 5; k++)
      add(0, 0, 1, 'hBB, 1, 1, 0, 0, 0, 1, 'hA2, 0, 1, 0);
    add(0, 1, 1, 'hA3, 1, 1, 1, 1, 0, 2, 'hA3, 0, 1, 0);
    add(0, 1, 1, 'hA4, 1, 1, 1, 1, 0, 3, 'hA4, 1, 1, 1);
    // Release buffer 1, then PixValid toggling
    add(0, 1, 0, 'h00, 1, 0, 0, 0, 0, 3, 'hA4, 1, 1, 0);
    add(0, 1, 0, 'h00, 1, 1, 0, 0, 0, 3, 'hA4, 1, 0, 0);
    add(0, 1, 0, 'h00, 1, 1, 0, 0, 0, 3, 'hA4, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      add(0, 1, 1, 'hC1 + k, 1, 1, 1, 0, 1, k, 'hC1 + k, 1, k == 3, k == 3);
      if (k < 3) add(0, 1, 0, 'hEE, 1, 1, 1, 0, 0, k, 'hC1 + k, 1, 0, 0);
    end
    add(0, 1, 0, 'h00, 1, 1, 0, 0, 0, 3, 'hC4, 1, 1, 0);
    // Release both, fill buffer 0, start buffer 1, reset at addr 3
    add(0, 1, 0, 'h00, 0, 0, 0, 0, 0, 3, 'hC4, 1, 1, 0);
    add(0, 1, 0, 'h00, 1, 1, 0, 0, 0, 3, 'hC4, 0, 0, 0);
    add(0, 1, 0, 'h00, 1, 1, 0, 0, 0, 3, 'hC4, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      add(0, 1, 1, 'hD1 + k, 1, 1, 1, 1, 0, k, 'hD1 + k, k == 3, 0, k == 3);
    add(0, 1, 1, 'hE1, 1, 1, 0, 0, 0, 3, 'hD4, 1, 0, 0);
    for (int k = 0; k < 3; k++)
      add(0, 1, 1, 'hE1 + k, 1, 1, 1, 0, 1, k, 'hE1 + k, 1, 0, 0);
    add(1, 1, 1, 'hE4, 1, 1, 1, 0, 0, 0, 'h00, 0, 0, 0);
    add(0, 1, 1, 'hF1, 1, 1, 0, 0, 0, 0, 'h00, 0, 0, 0);
    add(0, 1, 1, 'hF1, 1, 1, 0, 0, 0, 0, 'h00, 0, 0, 0);
    add(0, 1, 1, 'hF1, 1, 1, 1, 1, 0, 0, 'hF1, 0, 0, 0);

    foreach (vq[n]) begin
      drive(vq[n].rst, vq[n].c, vq[n].v, int'(vq[n].px), vq[n].z0, vq[n].z1);
      #1;
      chk($sformatf("v%0d.ready", n), {31'b0, ready}, {31'b0, vq[n].rdy});
      tick();
      $display("vec %0d rdy=%0b we0=%0b we1=%0b addr=%0d data=%06h f0=%0b f1=%0b ld=%0b",
               n, vq[n].rdy, we0, we1, wa, wd, f0, f1, ld);
      chk($sformatf("v%0d.we0", n), {31'b0, we0}, {31'b0, vq[n].w0});
      chk($sformatf("v%0d.we1", n), {31'b0, we1}, {31'b0, vq[n].w1});
      chk($sformatf("v%0d.addr", n), {30'b0, wa}, {30'b0, vq[n].addr});
      chk($sformatf("v%0d.data", n), {8'b0, wd}, {8'b0, vq[n].data});
      chk($sformatf("v%0d.full0", n), {31'b0, f0}, {31'b0, vq[n].fu0});
      chk($sformatf("v%0d.full1", n), {31'b0, f1}, {31'b0, vq[n].fu1});
      chk($sformatf("v%0d.done", n), {31'b0, ld}, {31'b0, vq[n].done});
    end

    // Empty rising edge on the first WAIT cycle of a full buffer: one extra WAIT cycle
    drive(1, 1, 0, 0, 1, 1);
    tick();
    drive(0, 1, 0, 0, 1, 1);
    tick();
    tick();
    chk("seq.ready_fill0", {31'b0, ready}, 1);
    fill_line('h100);
    chk("seq.full0_set", {31'b0, f0}, 1);
    chk("seq.last_wr", {6'b0, ld, we0, 24'(wd)}, {6'b0, 1'b1, 1'b1, 24'h103});
    tick();
    e0 = 1'b0;
    fill_line('h200);
    chk("seq.full1_set", {31'b0, f1}, 1);
    chk("seq.last_wr1", {30'b0, we1, we0}, 2'b10);
    drive(0, 1, 1, 'h300, 1, 1);
    #1;
    chk("seq.wait1_ready", {31'b0, ready}, 0);
    tick();
    chk("seq.full0_clr", {31'b0, f0}, 0);
    chk("seq.wait2_ready", {31'b0, ready}, 0);
    tick();
    chk("seq.fill_ready", {31'b0, ready}, 1);
    chk("seq.no_we", {31'b0, we0}, 0);
    tick();
    pv = 1'b0;
    chk("seq.first_wr", {5'b0, we0, 2'(wa), 24'(wd)}, {5'b0, 1'b1, 2'd0, 24'h300});
    $display("seq same-cycle edge: f0=%0b we0=%0b addr=%0d data=%06h", f0, we0, wa, wd);

`ifdef DA_WR_OVERRUN_EN
    drive(1, 1, 0, 0, 1, 1);
    tick();
    chk("ovr.reset", {31'b0, overrun}, 0);
    drive(0, 1, 0, 0, 1, 1);
    tick();
    tick();
    fill_line('h400);
    tick();
    fill_line('h500);
    tick();
    chk("ovr.quiet", {31'b0, overrun}, 0);
    pv = 1'b1;
    tick();
    pv = 1'b0;
    chk("ovr.set", {31'b0, overrun}, 1);
    tick();
    tick();
    tick();
    chk("ovr.sticky", {31'b0, overrun}, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ovr.cleared", {31'b0, overrun}, 0);
    $display("seq overrun: overrun=%0b", overrun);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
